// File: rtl/rf_wb_arb_if.sv
// Writeback bus between the result producers / issue logic and the register-file arbiter.
// The arbiter side uses the slave modport; the producer/regfile side uses master.
interface rf_wb_arb_if;
  logic        alu_vld;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        ld_vld;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_rdy;
  logic        ld_issue;
  logic [3:0]  ld_issue_addr;
  logic        we;
  logic [3:0]  dst_addr;
  logic [15:0] dst;
  logic [15:0] busy;
  logic        waw_err;

  modport slave (
    input  alu_vld, alu_addr, alu_data,
    input  ld_vld, ld_addr, ld_data,
    input  ld_issue, ld_issue_addr,
    output ld_rdy, we, dst_addr, dst, busy, waw_err
  );

  modport master (
    output alu_vld, alu_addr, alu_data,
    output ld_vld, ld_addr, ld_data,
    output ld_issue, ld_issue_addr,
    input  ld_rdy, we, dst_addr, dst, busy, waw_err
  );
endinterface

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: ALU results take priority, load results queue in a
// 2-entry FIFO, and a busy scoreboard tracks loads still in flight.
module rf_wb_arb (
  input logic           clk,
  input logic           rst_n,
  rf_wb_arb_if.slave    bus
);

  logic [1:0]  r_count;
  logic        r_head;
  logic [3:0]  r_fifoAddr [2];
  logic [15:0] r_fifoData [2];
  logic        r_we;
  logic [3:0]  r_dstAddr;
  logic [15:0] r_dst;
  logic [15:0] r_busy;
  logic        r_wawErr;

  logic        w_aluWr;
  logic        w_ldRdy;
  logic        w_push;
  logic        w_pop;
  logic        w_tail;
  logic [15:0] w_setMask;
  logic [15:0] w_clrMask;

  // Writes to r0 are discarded outright, so they never claim the port or the FIFO.
  assign w_aluWr   = bus.alu_vld && (bus.alu_addr != 4'd0);
  assign w_ldRdy   = (r_count != 2'd2);
  assign w_push    = bus.ld_vld && w_ldRdy && (bus.ld_addr != 4'd0);
  assign w_pop     = !w_aluWr && (r_count != 2'd0);
  assign w_tail    = r_head ^ r_count[0];
  assign w_setMask = (bus.ld_issue && (bus.ld_issue_addr != 4'd0)) ? (16'd1 << bus.ld_issue_addr) : 16'd0;
  assign w_clrMask = w_pop ? (16'd1 << r_fifoAddr[r_head]) : 16'd0;

  // FIFO payload needs no reset; r_count alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoAddr[w_tail] <= bus.ld_addr;
      r_fifoData[w_tail] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 2'd0;
      r_head    <= 1'b0;
      r_we      <= 1'b0;
      r_dstAddr <= 4'd0;
      r_dst     <= 16'd0;
      r_busy    <= 16'd0;
      r_wawErr  <= 1'b0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_we <= w_aluWr || w_pop;
      if (w_aluWr) begin
        r_dstAddr <= bus.alu_addr;
        r_dst     <= bus.alu_data;
      end else if (w_pop) begin
        r_dstAddr <= r_fifoAddr[r_head];
        r_dst     <= r_fifoData[r_head];
      end
      // Set is applied after clear so a new issue wins over a retiring load.
      r_busy <= (r_busy & ~w_clrMask) | w_setMask;
      if (w_aluWr && r_busy[bus.alu_addr]) begin
        r_wawErr <= 1'b1;
      end
    end
  end

  assign bus.ld_rdy   = w_ldRdy;
  assign bus.we       = r_we;
  assign bus.dst_addr = r_dstAddr;
  assign bus.dst      = r_dst;
  assign bus.busy     = r_busy;
  assign bus.waw_err  = r_wawErr;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the writeback rules.
module tb_rf_wb_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rf_wb_arb_if bus ();

  rf_wb_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } entry_t;

  entry_t      mQ[$];
  logic [15:0] mBusy;
  logic        mWe;
  logic [3:0]  mAddr;
  logic [15:0] mDst;
  logic        mWaw;

  int nVec = 0;
  int nMiss = 0;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMiss++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".we"},       16'(bus.we),       16'(mWe));
    checkOutput({tag, ".dst_addr"}, 16'(bus.dst_addr), 16'(mAddr));
    checkOutput({tag, ".dst"},      bus.dst,           mDst);
    checkOutput({tag, ".busy"},     bus.busy,          mBusy);
    checkOutput({tag, ".waw_err"},  16'(bus.waw_err),  16'(mWaw));
    checkOutput({tag, ".ld_rdy"},   16'(bus.ld_rdy),   16'(mQ.size() < 2));
  endtask

  task automatic modelReset();
    mQ.delete();
    mBusy = 16'd0;
    mWe   = 1'b0;
    mAddr = 4'd0;
    mDst  = 16'd0;
    mWaw  = 1'b0;
  endtask

  // Reference behaviour for one clock: ALU wins the port, otherwise the oldest load retires.
  task automatic modelStep();
    entry_t     e;
    bit         aluW;
    bit         rdy;
    bit         doClr;
    logic [3:0] clr;
    rdy   = (mQ.size() < 2);
    aluW  = bus.alu_vld && (bus.alu_addr != 4'd0);
    doClr = 0;
    clr   = 4'd0;
    if (aluW && mBusy[bus.alu_addr]) mWaw = 1'b1;
    if (aluW) begin
      mWe = 1'b1;
      mAddr = bus.alu_addr;
      mDst = bus.alu_data;
    end else if (mQ.size() != 0) begin
      e = mQ.pop_front();
      mWe = 1'b1;
      mAddr = e.addr;
      mDst = e.data;
      clr = e.addr;
      doClr = 1;
    end else begin
      mWe = 1'b0;
    end
    if (bus.ld_vld && rdy && (bus.ld_addr != 4'd0)) mQ.push_back({bus.ld_addr, bus.ld_data});
    if (doClr) mBusy[clr] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_addr != 4'd0)) mBusy[bus.ld_issue_addr] = 1'b1;
  endtask

  task automatic applyStimulus(input string tag,
                               input logic aluV, input logic [3:0] aluA, input logic [15:0] aluD,
                               input logic ldV, input logic [3:0] ldA, input logic [15:0] ldD,
                               input logic iss, input logic [3:0] issA);
    bus.alu_vld       = aluV;
    bus.alu_addr      = aluA;
    bus.alu_data      = aluD;
    bus.ld_vld        = ldV;
    bus.ld_addr       = ldA;
    bus.ld_data       = ldD;
    bus.ld_issue      = iss;
    bus.ld_issue_addr = issA;
    modelStep();
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
  endtask

  task automatic doReset(input string tag);
    bus.alu_vld  = 1'b0;
    bus.ld_vld   = 1'b0;
    bus.ld_issue = 1'b0;
    rst_n = 1'b0;
    #2;
    modelReset();
    checkModel({tag, ".async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkModel({tag, ".held"});
  endtask

  initial begin
    bus.alu_vld = 1'b0; bus.alu_addr = 4'd0; bus.alu_data = 16'd0;
    bus.ld_vld = 1'b0; bus.ld_addr = 4'd0; bus.ld_data = 16'd0;
    bus.ld_issue = 1'b0; bus.ld_issue_addr = 4'd0;
    modelReset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkModel("por");
    rst_n = 1'b1;
    idle("por.idle");

    // ALU path, then an ALU write to r0 that must not touch the port
    applyStimulus("alu5", 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    checkOutput("alu5.we", 16'(bus.we), 16'd1);
    checkOutput("alu5.dst", bus.dst, 16'hBEEF);
    idle("alu5.after");
    checkOutput("alu5.pulse", 16'(bus.we), 16'd0);
    applyStimulus("alu0", 1'b1, 4'd0, 16'h5555, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    checkOutput("alu0.we", 16'(bus.we), 16'd0);
    checkOutput("alu0.hold", bus.dst, 16'hBEEF);

    // Load path with scoreboard
    applyStimulus("iss7", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    checkOutput("iss7.busy", bus.busy, 16'h0080);
    idle("ld7.gap1");
    idle("ld7.gap2");
    applyStimulus("ld7", 1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h1234, 1'b0, 4'd0);
    checkOutput("ld7.n1.we", 16'(bus.we), 16'd0);
    idle("ld7.n2");
    checkOutput("ld7.we", 16'(bus.we), 16'd1);
    checkOutput("ld7.dst", bus.dst, 16'h1234);
    checkOutput("ld7.busy", bus.busy, 16'h0000);
    applyStimulus("ld0", 1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hDEAD, 1'b1, 4'd0);
    idle("ld0.after");
    checkOutput("ld0.we", 16'(bus.we), 16'd0);

    // Contention: ALU holds the port while two loads queue up in order
    applyStimulus("ct.c1", 1'b1, 4'd3, 16'hA001, 1'b1, 4'd1, 16'h0001, 1'b0, 4'd0);
    applyStimulus("ct.c2", 1'b1, 4'd3, 16'hA002, 1'b1, 4'd2, 16'h0002, 1'b0, 4'd0);
    checkOutput("ct.rdy", 16'(bus.ld_rdy), 16'd0);
    applyStimulus("ct.c3", 1'b1, 4'd3, 16'hA003, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    applyStimulus("ct.c4", 1'b1, 4'd3, 16'hA004, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    checkOutput("ct.alu4", bus.dst, 16'hA004);
    idle("ct.c5");
    checkOutput("ct.r1", 16'(bus.dst_addr), 16'd1);
    idle("ct.c6");
    checkOutput("ct.r2", bus.dst, 16'h0002);
    idle("ct.c7");

    // Simultaneous push/pop at count 1 together with set/clear of busy[4]
    applyStimulus("pp.iss4", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd4);
    applyStimulus("pp.ld4", 1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0);
    applyStimulus("pp.both", 1'b0, 4'd0, 16'd0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd4);
    checkOutput("pp.dst", bus.dst, 16'h4444);
    checkOutput("pp.busy4", 16'(bus.busy[4]), 16'd1);
    idle("pp.next");
    checkOutput("pp.order", bus.dst, 16'h6666);

    // WAW detection stays sticky until reset
    applyStimulus("waw.iss9", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd9);
    applyStimulus("waw.alu9", 1'b1, 4'd9, 16'h00AA, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
    checkOutput("waw.dst", bus.dst, 16'h00AA);
    checkOutput("waw.flag", 16'(bus.waw_err), 16'd1);
    applyStimulus("waw.ld9", 1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0);
    idle("waw.d1");
    checkOutput("waw.busy9", 16'(bus.busy[9]), 16'd0);
    checkOutput("waw.sticky", 16'(bus.waw_err), 16'd1);
    doReset("waw.rst");

    // Mid-stream reset with a full FIFO and busy = 0x0014
    applyStimulus("mr.iss2", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd2);
    applyStimulus("mr.iss4", 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd4);
    applyStimulus("mr.ld2", 1'b1, 4'd3, 16'h3001, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0);
    applyStimulus("mr.ld4", 1'b1, 4'd3, 16'h3002, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0);
    checkOutput("mr.busy", bus.busy, 16'h0014);
    checkOutput("mr.full", 16'(bus.ld_rdy), 16'd0);
    doReset("mr.rst");
    idle("mr.post1");
    idle("mr.post2");
    checkOutput("mr.nowrite", 16'(bus.we), 16'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rnd",
                    1'($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 99) < 50), 4'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 99) < 30), 4'($urandom_range(0, 15)));
      if (i == 200) doReset("rnd.rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Writeback arbiter that drives the register file's single write port (we, dst_addr, dst) from two result producers: the single-cycle ALU and the variable-latency load unit. ALU results have fixed priority. Load results are buffered in a 2-entry FIFO with a valid/ready handshake. A pending-load scoreboard (busy bits) lets issue logic detect RAW/WAW hazards. Outputs are registered on posedge clk, so they are stable when the register file samples them on negedge clk.

## Interface
- No parameters. Fixed: 16 registers, 16-bit data, load FIFO depth 2.
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- alu_vld  input  1  ALU result valid this cycle; no backpressure
- alu_addr  input  4  ALU destination register
- alu_data  input  16  ALU result
- ld_vld  input  1  load result valid
- ld_addr  input  4  load destination register
- ld_data  input  16  load result
- ld_rdy  output  1  load FIFO can accept this cycle
- ld_issue  input  1  a load has been issued to memory this cycle
- ld_issue_addr  input  4  destination of the issued load
- we  output  1  register file write enable (registered)
- dst_addr  output  4  register file write address (registered)
- dst  output  16  register file write data (registered)
- busy  output  16  bit i set = load to register i outstanding
- waw_err  output  1  sticky: ALU wrote a register with busy bit set

## Operation
- Register 0 is hardwired to zero; every write to address 0 is discarded.
  - ALU result to r0: ignored, does not occupy the write port.
  - Load result to r0 with ld_vld && ld_rdy: handshake completes, nothing is pushed.
  - ld_issue to r0: does not set busy[0]. busy[0] is always 0.
- Load FIFO: 2 entries of {addr[3:0], data[15:0]}, 2-bit count.
  - ld_rdy = (count != 2), combinational from state only.
  - Push when ld_vld && ld_rdy && ld_addr != 0.
- Per-cycle arbitration (computed from current inputs/state, applied at posedge):
  - alu_vld && alu_addr != 0: next we=1, dst_addr=alu_addr, dst=alu_data; FIFO is not popped.
  - else FIFO non-empty: pop head; next we=1, dst_addr/dst = head entry; clear busy[head addr].
  - else: next we=0; dst_addr/dst hold their previous values.
- Push and pop in the same cycle: count unchanged, order preserved (head pops, new entry goes to tail).
- No bypass: a load result always passes through the FIFO.
- Scoreboard:
  - ld_issue && ld_issue_addr != 0 sets busy[ld_issue_addr] at the next edge.
  - Set and clear of the same bit in the same cycle: set wins.
  - Upstream guarantees at most one outstanding load per register. This block does not check that.
- waw_err: set at posedge when alu_vld && alu_addr != 0 && busy[alu_addr]. It stays set until reset. The ALU write still proceeds.

## Timing
- Reset (asynchronous, immediate): we=0, dst_addr=0, dst=0, busy=0, waw_err=0, FIFO empty (count=0), ld_rdy=1.
- Reset mid-operation: FIFO contents and busy bits are dropped, no write is issued, and outputs take their reset values immediately.
- ALU latency: alu_vld in cycle N gives we=1 with that data during cycle N+1. The register file writes at the negedge of N+1.
- Load latency, uncontended: accepted in cycle N, enters FIFO at end of N, popped at end of N+1, so we=1 during cycle N+2.
- A load waits one extra cycle for every cycle an ALU write to a nonzero address is present.
- Continuous ALU traffic starves the FIFO. The ALU side is required to leave gaps; once full, ld_rdy stays 0 and the load unit stalls.
- busy bit clears at the same edge where the corresponding we/dst_addr become valid.
- we is a 1-cycle pulse per write. Back-to-back writes give we held high with dst_addr/dst changing every cycle.

## Test plan
- Reset: assert rst_n=0 mid-stream with FIFO holding 2 entries and busy=16'h0014 -> we=0, dst=0, busy=0, ld_rdy=1, waw_err=0 immediately; no write after release.
- ALU path: alu_vld with r5 = 16'hBEEF in cycle 3 -> we=1, dst_addr=5, dst=16'hBEEF in cycle 4 only. Repeat with alu_addr=0 -> we stays 0.
- Load path plus scoreboard:
  - ld_issue r7 in cycle 1 -> busy=16'h0080 from cycle 2.
  - ld_vld r7 = 16'h1234 in cycle 5 -> we=1, dst_addr=7, dst=16'h1234 in cycle 7.
  - busy returns to 0 in cycle 7.
- Contention:
  - Loads r1 = 16'h0001 and r2 = 16'h0002 accepted in cycles 1 and 2 while alu_vld is held in cycles 1–4 (r3) -> ld_rdy=0 in cycle 3.
  - ALU writes appear in cycles 2–5; loads write r1 in cycle 6 and r2 in cycle 7, in order.
- Simultaneous push/pop at count=1 -> count stays 1, FIFO order preserved. Set/clear of busy[4] in the same cycle -> busy[4]=1.
- WAW: busy[9] set and alu_vld r9 = 16'h00AA -> register 9 is written 16'h00AA and waw_err=1. waw_err stays 1 after busy[9] clears, until rst_n is asserted.
